// File: rtl/simon_game_progressive_pkg.sv
// simon_pkg: shared types and helpers for the Simon game core.
//   state_e      - game FSM states
//   DEF_*        - default widths derived from the default N_CH / MAX_LEN
//   ch_width()   - channel index width for a given channel count
//   lvl_width()  - level width for a given maximum sequence length
//   lowest_set() - index of the lowest set bit of a 16-bit vector
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXTEND,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        WIN,
        LOSE
    } state_e;

    localparam int MAX_CH      = 16;
    localparam int DEF_N_CH    = 8;
    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_CH_W    = $clog2(DEF_N_CH);
    localparam int DEF_LVL_W   = $clog2(DEF_MAX_LEN + 1);

    function automatic int ch_width(input int n_ch);
        return (n_ch > 2) ? $clog2(n_ch) : 1;
    endfunction

    function automatic int lvl_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Scanning from the top down leaves the lowest set bit as the winner.
    function automatic logic [3:0] lowest_set(input logic [MAX_CH-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = MAX_CH; i > 0; i--) begin
            if (v[i-1]) r = 4'(i - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/simon_game_progressive_if.sv
// simon_game_progressive_if: player-facing signals of the Simon core.
//   start - begin a new game (level-sampled)
//   sw    - asynchronous toggle switches, one per channel
//   led   - one-hot replay display
//   level - current sequence length
//   busy  - game in progress
//   win   - sequence completed at maximum length
//   lose  - wrong press or timeout
// master: the player side; slave: the game core.
interface simon_game_progressive_if #(
    parameter int N_CH    = 8,
    parameter int MAX_LEN = 16
);
    localparam int LVL_W = $clog2(MAX_LEN + 1);

    logic             start;
    logic [N_CH-1:0]  sw;
    logic [N_CH-1:0]  led;
    logic [LVL_W-1:0] level;
    logic             busy;
    logic             win;
    logic             lose;

    modport master (output start, sw, input led, level, busy, win, lose);
    modport slave  (input start, sw, output led, level, busy, win, lose);
endinterface

// File: rtl/simon_game_progressive_lfsr.sv
// simon_lfsr: 16-bit Galois LFSR (taps 16,14,13,11), stepping every cycle.
//   clk   - system clock
//   rst   - synchronous active-high reset, loads SEED
//   rnd_o - low OUT_W bits of the LFSR state
module simon_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rnd_o
);
    // A zero seed would lock the register; substitute 1 so it never sticks.
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED_NZ;
        else     lfsr_q <= lfsr_d;
    end

    assign rnd_o = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/simon_game_progressive.sv
// simon_game_progressive: progressive-length Simon memory game core.
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - slave side of simon_game_progressive_if (start, sw in; led, level,
//         busy, win, lose out)
// Each round appends one LFSR-derived channel, replays the sequence on led
// (one tick on, one tick off per entry), then checks switch toggles against
// it with a per-input timeout counted in ticks.
module simon_game_progressive
    import simon_pkg::*;
#(
    parameter int          N_CH          = 8,
    parameter int          MAX_LEN       = 16,
    parameter int          TICK_DIV      = 25_000_000,
    parameter int          TIMEOUT_TICKS = 5,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input logic                     clk,
    input logic                     rst,
    simon_game_progressive_if.slave bus
);
    localparam int CH_W   = ch_width(N_CH);
    localparam int LVL_W  = lvl_width(MAX_LEN);
    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TDIV_W = $clog2(TICK_DIV);
    localparam int TO_W   = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;

    logic [N_CH-1:0]   sw_meta_q, sw_sync_q;
    logic [N_CH-1:0]   sw_prev_q, sw_prev_d;
    logic [N_CH-1:0]   press_ev;
    logic [CH_W-1:0]   press_ch;

    logic [TDIV_W-1:0] tick_cnt_q;
    logic              tick, tick_clr;

    logic [CH_W-1:0]   rnd;
    logic [CH_W-1:0]   seq_q [MAX_LEN];
    logic [CH_W-1:0]   seq_cur;
    logic              seq_we;

    state_e            state_q, state_d;
    logic [LVL_W-1:0]  len_q, len_d;
    logic [LVL_W-1:0]  idx_q, idx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              last;
    logic [N_CH-1:0]   led;

    simon_lfsr #(
        .SEED  (SEED),
        .OUT_W (CH_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .rnd_o (rnd)
    );

    // Two-flop synchroniser; left unreset so sw_prev can load a settled value.
    always_ff @(posedge clk) begin
        sw_meta_q <= bus.sw;
        sw_sync_q <= sw_meta_q;
    end

    assign tick = (tick_cnt_q == TDIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick_clr || tick) tick_cnt_q <= '0;
        else                         tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (seq_we) seq_q[len_q[IDX_W-1:0]] <= rnd;
    end

    assign seq_cur  = seq_q[idx_q[IDX_W-1:0]];
    assign last     = (idx_q == LVL_W'(len_q - 1'b1));
    assign press_ev = sw_sync_q ^ sw_prev_q;
    assign press_ch = CH_W'(lowest_set(16'(press_ev)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            to_cnt_q  <= '0;
            sw_prev_q <= sw_sync_q;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            to_cnt_q  <= to_cnt_d;
            sw_prev_q <= sw_prev_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        to_cnt_d  = to_cnt_q;
        // Outside WAIT_IN the edge detector tracks the switches, so toggles
        // made during replay or idle never surface later as presses.
        sw_prev_d = sw_sync_q;
        tick_clr  = 1'b0;
        seq_we    = 1'b0;

        case (state_q)
            IDLE, WIN, LOSE: begin
                if (bus.start) begin
                    len_d   = '0;
                    state_d = EXTEND;
                end
            end
            EXTEND: begin
                seq_we   = 1'b1;
                len_d    = len_q + 1'b1;
                idx_d    = '0;
                tick_clr = 1'b1;
                state_d  = SHOW_ON;
            end
            SHOW_ON: begin
                if (tick) state_d = SHOW_OFF;
            end
            SHOW_OFF: begin
                if (tick) begin
                    if (last) begin
                        idx_d    = '0;
                        to_cnt_d = '0;
                        state_d  = WAIT_IN;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SHOW_ON;
                    end
                end
            end
            WAIT_IN: begin
                sw_prev_d = sw_prev_q;
                // A press takes priority over a timeout tick in the same cycle.
                if (|press_ev) begin
                    sw_prev_d = sw_sync_q;
                    if (press_ch != seq_cur) begin
                        state_d = LOSE;
                    end else if (!last) begin
                        idx_d    = idx_q + 1'b1;
                        to_cnt_d = '0;
                    end else if (int'(len_q) == MAX_LEN) begin
                        state_d = WIN;
                    end else begin
                        state_d = EXTEND;
                    end
                end else if (tick) begin
                    if (int'(to_cnt_q) + 1 >= TIMEOUT_TICKS) state_d = LOSE;
                    else                                     to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        led = '0;
        if (state_q == SHOW_ON) led = N_CH'(1) << seq_cur;
    end

    assign bus.led   = led;
    assign bus.level = len_q;
    assign bus.busy  = !(state_q == IDLE || state_q == WIN || state_q == LOSE);
    assign bus.win   = (state_q == WIN);
    assign bus.lose  = (state_q == LOSE);
endmodule

// File: tb/tb_simon_game_progressive.sv
// Directed bench for simon_game_progressive with N_CH=4, MAX_LEN=3,
// TICK_DIV=4, TIMEOUT_TICKS=3. Expected sequence entries come from a
// reference Galois LFSR stepped alongside the design.
module tb_simon_game_progressive;
    import simon_pkg::*;

    localparam int          N_CH          = 4;
    localparam int          MAX_LEN       = 3;
    localparam int          TICK_DIV      = 4;
    localparam int          TIMEOUT_TICKS = 3;
    localparam logic [15:0] SEED          = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simon_game_progressive_if #(.N_CH(N_CH), .MAX_LEN(MAX_LEN)) bus ();

    simon_game_progressive #(
        .N_CH          (N_CH),
        .MAX_LEN       (MAX_LEN),
        .TICK_DIV      (TICK_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .SEED          (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] lfsr_m;
    logic [15:0] lfsr_prev;
    logic [1:0]  exp_seq [MAX_LEN];

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        lfsr_m    <= rst ? SEED : lfsr_step(lfsr_m);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic toggle(input logic [1:0] ch);
        bus.sw[ch] = ~bus.sw[ch];
    endtask

    // Wait for the first SHOW_ON of round L; the entry just stored is the
    // reference LFSR value from the EXTEND cycle.
    task automatic wait_round(input int L);
        int k;
        k = 0;
        while (!(int'(bus.level) == L && bus.led != 4'b0000) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("round%0d_start", L), 32'(k < 40), 32'd1);
        chk($sformatf("round%0d_level", L), 32'(bus.level), 32'(L));
        exp_seq[L-1] = lfsr_prev[1:0];
    endtask

    // Check every replay cycle; optionally toggle switches mid-replay and/or
    // pulse rst during the third SHOW_ON.
    task automatic replay(input int L, input bit tog, input bit rst_mid, output bit aborted);
        logic [3:0] exp_led;
        aborted = 1'b0;
        chk($sformatf("busy_r%0d", L), 32'(bus.busy), 32'd1);
        for (int i = 0; i < L && !aborted; i++) begin
            for (int c = 0; c < 2 * TICK_DIV && !aborted; c++) begin
                exp_led = (c < TICK_DIV) ? (4'b0001 << exp_seq[i]) : 4'b0000;
                chk($sformatf("led_r%0d_i%0d_c%0d", L, i, c), 32'(bus.led), 32'(exp_led));
                if (tog && i * 8 + c == 1) toggle(2'd0);
                if (tog && i * 8 + c == 9) toggle(2'd2);
                if (rst_mid && i * 8 + c == 18) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    aborted = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ab;
        int          k;
        logic [1:0]  wrong;
        logic [15:0] nxt;

        bus.start = 1'b0;
        bus.sw    = '0;
        rst       = 1'b1;

        // Reset and idle
        cyc(3);
        chk("rst_outputs", 32'({bus.led, bus.level, bus.busy, bus.win, bus.lose}), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_outputs", 32'({bus.led, bus.level, bus.busy, bus.win, bus.lose}), 32'd0);
        end
        chk("idle_state", 32'(dut.state_q), 32'(IDLE));

        // Full game to a win
        pulse_start();
        for (int L = 1; L <= MAX_LEN; L++) begin
            wait_round(L);
            replay(L, 1'b0, 1'b0, ab);
            for (int i = 0; i < L; i++) begin
                toggle(exp_seq[i]);
                cyc(2);
                if (L == MAX_LEN && i == L - 1) chk("win_early", 32'(bus.win), 32'd0);
                cyc(1);
                chk("lose_in_play", 32'(bus.lose), 32'd0);
            end
        end
        chk("win", 32'(bus.win), 32'd1);
        chk("win_busy", 32'(bus.busy), 32'd0);
        chk("win_level", 32'(bus.level), 32'd3);

        // Wrong first input in round 2
        pulse_start();
        wait_round(1);
        replay(1, 1'b0, 1'b0, ab);
        toggle(exp_seq[0]);
        cyc(3);
        wait_round(2);
        replay(2, 1'b0, 1'b0, ab);
        wrong = exp_seq[0] + 2'd1;
        toggle(wrong);
        cyc(2);
        chk("wrong_lose_early", 32'(bus.lose), 32'd0);
        cyc(1);
        chk("wrong_lose", 32'(bus.lose), 32'd1);
        chk("wrong_level", 32'(bus.level), 32'd2);
        chk("wrong_busy", 32'(bus.busy), 32'd0);

        // Timeout with no input
        pulse_start();
        wait_round(1);
        replay(1, 1'b0, 1'b0, ab);
        k = 0;
        while (!bus.lose && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_window", 32'(k >= 8 && k <= 12), 32'd1);
        chk("timeout_level", 32'(bus.level), 32'd1);

        // Pick a start cycle so that seq[0] = 1
        k = 0;
        nxt = lfsr_step(lfsr_m);
        while (nxt[1:0] != 2'd1 && k < 200) begin
            @(negedge clk);
            nxt = lfsr_step(lfsr_m);
            k++;
        end
        pulse_start();
        wait_round(1);
        chk("seq0_is_ch1", 32'(bus.led), 32'h2);
        replay(1, 1'b0, 1'b0, ab);
        toggle(2'd3);
        toggle(2'd1);
        cyc(3);
        chk("multi_lose", 32'(bus.lose), 32'd0);
        wait_round(2);
        // Toggles during replay must not become presses
        replay(2, 1'b1, 1'b0, ab);
        toggle(2'd3);
        toggle(2'd1);
        cyc(3);
        chk("multi2_lose", 32'(bus.lose), 32'd0);
        cyc(2);
        chk("multi2_no_second", 32'({bus.level, bus.lose, bus.busy}), 32'({2'd2, 1'b0, 1'b1}));
        toggle(exp_seq[1]);
        cyc(3);
        wait_round(3);

        // Reset in the middle of SHOW_ON
        replay(3, 1'b0, 1'b1, ab);
        chk("rst_mid_aborted", 32'(ab), 32'd1);
        chk("rst_mid_led", 32'(bus.led), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_level", 32'(bus.level), 32'd0);
        chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        cyc(5);
        chk("post_rst_idle", 32'({bus.led, bus.level, bus.busy, bus.win, bus.lose}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
